// File: rtl/bitmanip_pkg.sv
// Shared bitmanip definitions: FSM state encoding, legal XLEN values and the
// single-stage GREV/GORC reference used by the iterative permutation units.
package bitmanip_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int XLEN_LEGAL_A = 32;
  localparam int XLEN_LEGAL_B = 64;
  localparam int XLEN_MAX     = 64;

  function automatic logic xlen_ok(input int xlen);
    xlen_ok = (xlen == XLEN_LEGAL_A) || (xlen == XLEN_LEGAL_B);
  endfunction

  // One butterfly stage k: swap bits at distance 2^k, OR-ing in the original
  // bits when orc is set. Operands narrower than XLEN_MAX are zero-extended;
  // swaps never cross into the padding because k < log2(width).
  function automatic logic [XLEN_MAX-1:0] grev_stage(
    input logic [XLEN_MAX-1:0] x,
    input int                  k,
    input logic                en,
    input logic                orc
  );
    logic [XLEN_MAX-1:0] sw;
    for (int i = 0; i < XLEN_MAX; i++) begin
      sw[i] = x[i ^ (32'sd1 << k)];
    end
    grev_stage = en ? (orc ? (x | sw) : sw) : x;
  endfunction

endpackage

// File: rtl/iter_grev_stage.sv
// Combinational slice of the iterative GREV: applies up to SPC consecutive
// butterfly stages starting at stage index cnt_i*SPC, skipping stages >= LOG2.
module iter_grev_stage
  import bitmanip_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SPC   = 1,
  parameter int CNT_W = 1,
  parameter int LOG2  = $clog2(XLEN)
) (
  input  logic [XLEN-1:0]  data_i,
  input  logic [LOG2-1:0]  ctrl_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             orc_i,
  output logic [XLEN-1:0]  data_o
);

  logic [XLEN-1:0] x_s;

  // Chain the selected stages in ascending order; at most one s matches each j.
  always_comb begin
    x_s = data_i;
    for (int j = 0; j < SPC; j++) begin
      for (int s = 0; s < LOG2; s++) begin
        x_s = XLEN'(grev_stage(64'(x_s), s,
                               ((int'(cnt_i) * SPC + j) == s) && ctrl_i[s],
                               orc_i));
      end
    end
  end

  assign data_o = x_s;

endmodule

// File: rtl/iter_grev.sv
// Iterative GREV unit with valid/ready handshake, SPC stages per cycle.
// Optional GORC support is compiled in with `define ITER_GREV_GORC_EN.
module iter_grev
  import bitmanip_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int SPC  = 1,
  localparam int LOG2 = $clog2(XLEN)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [LOG2-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rd,
  output logic            busy
);

  localparam int NCYC  = (LOG2 + SPC - 1) / SPC;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

  if (!xlen_ok(XLEN) || (SPC < 1) || (SPC > LOG2)) begin : g_param_check
    $error("iter_grev: illegal XLEN/SPC combination");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [LOG2-1:0]  ctrl_q, ctrl_d;
  logic [XLEN-1:0]  rd_q, rd_d;
  logic [XLEN-1:0]  stage_s;
  logic             accept_s;
  logic             load_s;
  logic             orc_s;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign out_rd    = rd_q;

`ifdef ITER_GREV_GORC_EN
  logic op_q, op_d;

  assign op_d  = load_s ? in_op : op_q;
  assign orc_s = op_q;

  // Operation select is captured together with the operands.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q <= 1'b0;
    end else begin
      op_q <= op_d;
    end
  end
`else
  logic op_unused;

  assign op_unused = in_op;
  assign orc_s     = 1'b0;
`endif

  iter_grev_stage #(
    .XLEN  (XLEN),
    .SPC   (SPC),
    .CNT_W (CNT_W)
  ) u_stage (
    .data_i (data_q),
    .ctrl_i (ctrl_q),
    .cnt_i  (cnt_q),
    .orc_i  (orc_s),
    .data_o (stage_s)
  );

  // Next-state logic; out_rd is only loaded on the final RUN cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    load_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          load_s  = 1'b1;
          data_d  = in_rs1;
          ctrl_d  = in_rs2;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        data_d = stage_s;
        if (cnt_q == CNT_LAST) begin
          rd_d    = stage_s;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (accept_s) begin
          load_s  = 1'b1;
          data_d  = in_rs1;
          ctrl_d  = in_rs2;
          cnt_d   = '0;
          state_d = RUN;
        end else if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and datapath registers; reset drops any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_iter_grev.sv
// Self-checking bench for iter_grev: three configurations driven in lockstep,
// a per-cycle reference model and directed literal checks.
module tb_iter_grev;

  localparam int NC [3] = '{5, 1, 3};
  localparam int XL [3] = '{32, 32, 64};
`ifdef ITER_GREV_GORC_EN
  localparam bit GORC_ON = 1'b1;
`else
  localparam bit GORC_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_op;
  logic        out_ready;
  logic [63:0] rs1;
  logic [5:0]  rs2;
  logic [2:0]  rdy, vld, bsy;
  logic [31:0] rd0, rd1;
  logic [63:0] rd2;
  logic [63:0] rd_v [3];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int          m_st   [3];
  int          m_left [3];
  logic [63:0] m_rd   [3];
  logic [63:0] m_pend [3];

  always #5 clock = ~clock;

  iter_grev #(.XLEN(32), .SPC(1)) u_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_op(in_op), .in_rs1(rs1[31:0]), .in_rs2(rs2[4:0]), .out_valid(vld[0]),
    .out_ready(out_ready), .out_rd(rd0), .busy(bsy[0]));

  iter_grev #(.XLEN(32), .SPC(5)) u_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_op(in_op), .in_rs1(rs1[31:0]), .in_rs2(rs2[4:0]), .out_valid(vld[1]),
    .out_ready(out_ready), .out_rd(rd1), .busy(bsy[1]));

  iter_grev #(.XLEN(64), .SPC(2)) u_c (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_op(in_op), .in_rs1(rs1), .in_rs2(rs2), .out_valid(vld[2]),
    .out_ready(out_ready), .out_rd(rd2), .busy(bsy[2]));

  assign rd_v[0] = {32'h0, rd0};
  assign rd_v[1] = {32'h0, rd1};
  assign rd_v[2] = rd2;

  // grev: out[i] = x[i ^ c]; gorc: out[i] = OR of x[i ^ m] over every m within c.
  function automatic logic [63:0] ref_perm(input logic [63:0] x, input logic [5:0] ctrl,
                                           input logic orc, input int xl);
    logic [63:0] r;
    logic        b;
    int          c;
    r = '0;
    c = int'(ctrl) & (xl - 1);
    for (int i = 0; i < xl; i++) begin
      if (orc) begin
        b = 1'b0;
        for (int m = 0; m < 64; m++) begin
          if ((m & ~c) == 0) b = b | x[i ^ m];
        end
        r[i] = b;
      end else begin
        r[i] = x[i ^ c];
      end
    end
    return r;
  endfunction

  function automatic logic exp_rdy(input int st);
    return (st == 0) || ((st == 2) && out_ready);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: accept at edge t, result visible from edge t+NC, held until taken.
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_st[i]   <= 0;
        m_left[i] <= 0;
        m_rd[i]   <= '0;
      end else if (in_valid && exp_rdy(m_st[i])) begin
        m_st[i]   <= 1;
        m_left[i] <= NC[i];
        m_pend[i] <= ref_perm(rs1, rs2, GORC_ON & in_op, XL[i]);
      end else if (m_st[i] == 1) begin
        m_left[i] <= m_left[i] - 1;
        if (m_left[i] == 1) begin
          m_st[i] <= 2;
          m_rd[i] <= m_pend[i];
        end
      end else if ((m_st[i] == 2) && out_ready) begin
        m_st[i] <= 0;
      end
    end
  end

  // Compare every observable output against the model once per cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("cyc_rdy%0d", i), {63'h0, rdy[i]}, {63'h0, exp_rdy(m_st[i])});
        chk($sformatf("cyc_vld%0d", i), {63'h0, vld[i]}, {63'h0, m_st[i] == 2});
        chk($sformatf("cyc_bsy%0d", i), {63'h0, bsy[i]}, {63'h0, m_st[i] == 1});
        chk($sformatf("cyc_rd%0d", i), rd_v[i], m_rd[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [5:0] b, input logic op);
    rs1      = a;
    rs2      = b;
    in_op    = op;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_req(input string name, input logic [63:0] a, input logic [5:0] b,
                         input logic op, input logic [63:0] ea, input logic [63:0] eb,
                         input logic [63:0] ec);
    send(a, b, op);
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk({name, "_lat_a"}, {63'h0, vld[0]}, {63'h0, c >= 5});
      chk({name, "_lat_b"}, {63'h0, vld[1]}, 64'h1);
      chk({name, "_lat_c"}, {63'h0, vld[2]}, {63'h0, c >= 3});
    end
    chk({name, "_rd_a"}, rd_v[0], ea);
    chk({name, "_rd_b"}, rd_v[1], eb);
    chk({name, "_rd_c"}, rd_v[2], ec);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_drain"}, {61'h0, vld}, 64'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    out_ready = 1'b0;
    rs1       = '0;
    rs2       = '0;

    chk("ref_t1",   ref_perm(64'h1, 6'd31, 1'b0, 32), 64'h80000000);
    chk("ref_t2",   ref_perm(64'h12345678, 6'd24, 1'b0, 32), 64'h78563412);
    chk("ref_t3",   ref_perm(64'h0123456789ABCDEF, 6'd56, 1'b0, 64), 64'hEFCDAB8967452301);
    chk("ref_gorc", ref_perm(64'h1, 6'd7, 1'b1, 32), 64'hFF);

    repeat (3) tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("rst_rdy", {61'h0, rdy}, 64'h7);
    chk("rst_vld", {61'h0, vld}, 64'h0);
    chk("rst_rd",  {32'h0, rd0}, 64'h0);

    run_req("t1",   64'h1, 6'd31, 1'b0, 64'h80000000, 64'h80000000, 64'h80000000);
    run_req("t2",   64'h12345678, 6'd24, 1'b0, 64'h78563412, 64'h78563412, 64'h78563412);
    run_req("zero", 64'h12345678, 6'd0, 1'b0, 64'h12345678, 64'h12345678, 64'h12345678);
    run_req("t3",   64'h0123456789ABCDEF, 6'd56, 1'b0,
            64'hEFCDAB89, 64'hEFCDAB89, 64'hEFCDAB8967452301);
`ifdef ITER_GREV_GORC_EN
    run_req("gorc", 64'h1, 6'd7, 1'b1, 64'hFF, 64'hFF, 64'hFF);
`else
    run_req("gorc", 64'h1, 6'd7, 1'b1, 64'h80, 64'h80, 64'h80);
`endif

    // Backpressure: competing requests are ignored while the result waits.
    send(64'h1, 6'd31, 1'b0);
    rs1      = 64'h12345678;
    rs2      = 6'd24;
    in_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("bp_rdy", {63'h0, rdy[0]}, 64'h0);
      if (c >= 5) chk("bp_rd", rd_v[0], 64'h80000000);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_busy", {61'h0, bsy}, 64'h7);
    repeat (5) tick();
    chk("bp_new", rd_v[0], 64'h78563412);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset two cycles after accept discards the operation.
    send(64'h1, 6'd31, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_run_rdy", {63'h0, rdy[0]}, 64'h1);
    for (int c = 0; c < 8; c++) begin
      chk("rst_run_vld", {61'h0, vld}, 64'h0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
